m_uart_loader: RTL
==================

# m_uart_loader

UART program loader that fills the processor's 4K-word instruction memory over a serial line before execution starts. It sits directly upstream of `m_proc08`'s instruction memory write port: it receives a word count, then little-endian 32-bit words, and issues one memory write per word. When the load completes it asserts `r_done`, which the top level uses to hold the processor in reset until then.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be at least 4.
- `ADDR_W`, default 12: word-address width; capacity is 2^ADDR_W words.
- `w_clk  in  1`: system clock; all logic is on the rising edge.
- `w_rst  in  1`: asynchronous, active-high reset.
- `w_rxd  in  1`: UART receive line. Idle high, 8N1, LSB first. Asynchronous to `w_clk`.
- `r_we  out  1`: one-cycle instruction-memory write strobe.
- `r_addr  out  ADDR_W`: word address for the write.
- `r_wdata  out  32`: write data.
- `r_done  out  1`: load complete. Sticky until reset.
- `r_err  out  1`: framing error seen. Sticky until reset.

## Operation
- **Input sync:** `w_rxd` passes through a 2-flop synchronizer. All RX logic uses the synchronized value.
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the line is low. The bit counter is cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample the line. If low → DATA. If high (glitch) → IDLE, with no byte and no error.
  - DATA: sample 8 bits, each CLKS_PER_BIT cycles apart, at mid-bit. Shift LSB first. → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - High: emit a 1-cycle byte-valid pulse with the byte.
    - Low: set `r_err`, discard the byte, emit no pulse.
    - In both cases → IDLE.
- **Loader FSM states:** HDR0, HDR1, WORD, DONE.
  - HDR0: byte → count[7:0]. → HDR1.
  - HDR1: byte → count[15:8].
    - If count is 0 → DONE.
    - If count exceeds 2^ADDR_W, it saturates to 2^ADDR_W.
    - Otherwise → WORD, with byte index 0 and address 0.
  - WORD: bytes fill the assembly register little-endian (byte 0 → [7:0], ..., byte 3 → [31:24]).
    - On the 4th byte: `r_wdata` = the assembled word, `r_addr` = the current address, `r_we` = 1 for one cycle.
    - Then the address increments and the byte index returns to 0.
    - After the write for word count−1 → DONE.
  - DONE: `r_done` = 1. All further bytes are ignored; no writes occur.
- **Framing errors:** a discarded byte does not advance the loader. Subsequent bytes continue to be assembled.
- **Reset mid-load:** all state is cleared and the next byte is treated as HDR0. Memory contents already written are not touched.
- **Address arithmetic:** `r_addr` is ADDR_W bits wide. It never wraps, because of count saturation.

## Timing
- **Reset values:** `r_we`=0, `r_addr`=0, `r_wdata`=0, `r_done`=0, `r_err`=0. Both FSMs are in their first state (IDLE, HDR0). Sync flops are 1.
- **Byte-valid pulse:** the cycle after the stop-bit sample point. The sample point is 2 sync cycles + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT after the start-bit falling edge.
- **Write strobe:** `r_we` rises the cycle after the byte-valid pulse of a word's 4th byte.
  - `r_addr` and `r_wdata` are valid in the same cycle as `r_we`.
  - `r_addr` and `r_wdata` hold their values until the next write.
- **Done:**
  - `r_done` rises in the same cycle as the final `r_we`'s successor, i.e. 1 cycle after the last write strobe.
  - For count 0, `r_done` rises 1 cycle after the HDR1 byte-valid pulse.
- **Error:** `r_err` rises 1 cycle after a failed stop-bit sample.
- **Throughput:** at most one write per 40 bit times. Back-to-back frames with no idle gap between stop and next start must be accepted.

## Structure
- Shared package holds:
  - the loader state encodings (HDR0/HDR1/WORD/DONE);
  - the RX state encodings;
  - `DEFAULT_CLKS_PER_BIT` = 868.
- Sub-module `m_uart_rx` contains the synchronizer, the RX FSM, the bit counter and the shift register.
  - Ports: `w_clk`, `w_rst`, `w_rxd`, `r_valid`, `r_data[7:0]`, `r_ferr`.
- `m_uart_loader` contains the loader FSM, the word assembly, the address counter and the output registers.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and ideal bit timing.
1. **Reset and idle:** assert reset with the line high, then hold the line high for 200 cycles → all outputs stay 0 and no `r_we`.
2. **Single word:** send 01 00 78 56 34 12 → exactly one `r_we` with `r_addr`=0 and `r_wdata`=0x12345678. `r_done` rises the next cycle and `r_err` stays 0.
3. **Two words, back-to-back frames:** send 02 00 EF BE AD DE 01 00 00 00 → writes (0, 0xDEADBEEF) then (1, 0x00000001). `r_done` rises after the second write; trailing bytes AA BB cause no writes.
4. **Glitch and framing error:**
   - Inject a 1-cycle low pulse on an idle line → no byte and no error.
   - Send a frame with the stop bit low → `r_err`=1 and that byte is dropped.
   - The following 01 00 44 33 22 11 then writes 0x11223344 at address 0.
5. **Zero count:** send 00 00 → `r_done`=1 with no `r_we`. Subsequent 01 00 … bytes are ignored.
6. **Reset mid-word:** send 01 00 AA BB, pulse `w_rst`, then send 01 00 04 03 02 01 → a single write of 0x01020304 at address 0. No write containing AA/BB occurs.

Source files
------------

// File: rtl/m_uart_loader_pkg.sv
// Shared encodings and defaults for the UART program loader and its receiver.
package m_uart_loader_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_HDR0 = 2'd0,
    LD_HDR1 = 2'd1,
    LD_WORD = 2'd2,
    LD_DONE = 2'd3
  } ld_state_t;

endpackage

// File: rtl/m_uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and shift register.
module m_uart_rx
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rxd,
  output logic       r_valid,
  output logic [7:0] r_data,
  output logic       r_ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             rxd_s1;
  logic             rxd_s2;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             armed;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      rxd_s1  <= 1'b1;
      rxd_s2  <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      armed   <= 1'b1;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
    end else begin
      rxd_s1  <= w_rxd;
      rxd_s2  <= rxd_s1;
      r_valid <= 1'b0;
      case (state)
        // A failed stop bit leaves the line low; wait for it to rise so the
        // same low level is not mistaken for a new start bit.
        RX_IDLE: begin
          if (rxd_s2) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rxd_s2, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rxd_s2) begin
              r_valid <= 1'b1;
              r_data  <= shreg;
            end else begin
              r_ferr <= 1'b1;
              armed  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/m_uart_loader.sv
// Serial program loader: word count header, then little-endian 32-bit words written
// sequentially into instruction memory; r_done releases the processor.
module m_uart_loader
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 12
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_done,
  output logic              r_err
);

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  // Address of the final word; counts above capacity clamp so the pointer never wraps.
  function automatic logic [ADDR_W-1:0] last_addr_sat(input logic [15:0] count);
    if ({1'b0, count} > CAP) return '1;
    return ADDR_W'(count - 16'd1);
  endfunction

  logic              rx_vld_p0;
  logic [7:0]        rx_byte_p0;
  ld_state_t         state;
  logic [7:0]        cnt_lo;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_p1;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       count;

  m_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .w_rxd  (w_rxd),
    .r_valid(rx_vld_p0),
    .r_data (rx_byte_p0),
    .r_ferr (r_err)
  );

  assign count = {rx_byte_p0, cnt_lo};

  // p0 -> p1: received byte drives the loader FSM and the registered memory port
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state     <= LD_HDR0;
      cnt_lo    <= '0;
      byte_idx  <= '0;
      asm_p1    <= '0;
      last_addr <= '0;
      wr_ptr    <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (state == LD_DONE) r_done <= 1'b1;
      if (rx_vld_p0) begin
        case (state)
          LD_HDR0: begin
            cnt_lo <= rx_byte_p0;
            state  <= LD_HDR1;
          end
          LD_HDR1: begin
            if (count == 16'd0) begin
              state  <= LD_DONE;
              r_done <= 1'b1;
            end else begin
              last_addr <= last_addr_sat(count);
              wr_ptr    <= '0;
              byte_idx  <= '0;
              state     <= LD_WORD;
            end
          end
          LD_WORD: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_p1[7:0]   <= rx_byte_p0;
              2'd1: asm_p1[15:8]  <= rx_byte_p0;
              2'd2: asm_p1[23:16] <= rx_byte_p0;
              default: begin
                r_we    <= 1'b1;
                r_addr  <= wr_ptr;
                r_wdata <= {rx_byte_p0, asm_p1};
                wr_ptr  <= wr_ptr + 1'b1;
                if (wr_ptr == last_addr) state <= LD_DONE;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
